// File: rtl/pass_entry_ctrl_if.sv
// Handshake and register-bank bus between the digit source, the entry controller
// and the entry-register bank.
interface pass_entry_ctrl_if;
    logic       enter;
    logic [3:0] digit;
    logic [3:0] reg_load;
    logic [3:0] reg_data;
    logic       reg_clr;
    logic [1:0] digit_idx;
    logic       access;
    logic       bad;
    logic       locked;
    logic [3:0] tries_left;

    modport master (
        output enter, digit,
        input  reg_load, reg_data, reg_clr, digit_idx, access, bad, locked, tries_left
    );

    modport slave (
        input  enter, digit,
        output reg_load, reg_data, reg_clr, digit_idx, access, bad, locked, tries_left
    );
endinterface

// File: rtl/pass_entry_ctrl.sv
// Password entry sequencer: steers four digits into the entry bank, checks the code,
// counts failures and locks out. PEC_LOCK_TIMER_EN enables a timed lockout release.
module pass_entry_ctrl #(
    parameter logic [15:0]  PASSWORD    = 16'h1234,
    parameter int unsigned  MAX_TRIES   = 3,
    parameter int unsigned  LOCK_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rts,
    pass_entry_ctrl_if.slave bus
);
    localparam int unsigned TRIES_W = 4;
    localparam logic [TRIES_W-1:0] TRIES_INIT = TRIES_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_ENTRY, ST_CHECK, ST_FAIL, ST_GRANTED, ST_LOCKED
    } state_t;

    state_t             r_state,    w_state_d;
    logic [15:0]        r_shadow,   w_shadow_d;
    logic [1:0]         r_idx,      w_idx_d;
    logic [3:0]         r_reg_load, w_reg_load_d;
    logic [3:0]         r_reg_data, w_reg_data_d;
    logic               r_reg_clr,  w_reg_clr_d;
    logic               r_access,   w_access_d;
    logic               r_bad,      w_bad_d;
    logic               r_locked,   w_locked_d;
    logic [TRIES_W-1:0] r_tries,    w_tries_d;
    logic [TRIES_W-1:0] w_tries_dec;

`ifdef PEC_LOCK_TIMER_EN
    localparam int unsigned CNT_W = 20;
    localparam logic [CNT_W-1:0] LOCK_INIT = CNT_W'(LOCK_CYCLES);
    logic [CNT_W-1:0]   r_lock_cnt, w_lock_cnt_d;
`endif

    assign w_tries_dec = r_tries - TRIES_W'(1);

    always_ff @(posedge clk) begin
        if (rts) begin
            r_state    <= ST_ENTRY;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_reg_load <= '0;
            r_reg_data <= '0;
            r_reg_clr  <= 1'b1;
            r_access   <= 1'b0;
            r_bad      <= 1'b0;
            r_locked   <= 1'b0;
            r_tries    <= TRIES_INIT;
        end else begin
            r_state    <= w_state_d;
            r_shadow   <= w_shadow_d;
            r_idx      <= w_idx_d;
            r_reg_load <= w_reg_load_d;
            r_reg_data <= w_reg_data_d;
            r_reg_clr  <= w_reg_clr_d;
            r_access   <= w_access_d;
            r_bad      <= w_bad_d;
            r_locked   <= w_locked_d;
            r_tries    <= w_tries_d;
        end
    end

`ifdef PEC_LOCK_TIMER_EN
    always_ff @(posedge clk) begin
        if (rts) r_lock_cnt <= '0;
        else     r_lock_cnt <= w_lock_cnt_d;
    end
`endif

    // Next state and next registered outputs; strobes default low, levels recomputed.
    always_comb begin
        w_state_d    = r_state;
        w_shadow_d   = r_shadow;
        w_idx_d      = r_idx;
        w_reg_load_d = 4'b0000;
        w_reg_data_d = r_reg_data;
        w_reg_clr_d  = 1'b0;
        w_access_d   = 1'b0;
        w_bad_d      = 1'b0;
        w_locked_d   = 1'b0;
        w_tries_d    = r_tries;
`ifdef PEC_LOCK_TIMER_EN
        w_lock_cnt_d = r_lock_cnt;
`endif
        unique case (r_state)
            ST_ENTRY: begin
                if (bus.enter) begin
                    unique case (r_idx)
                        2'd0: w_shadow_d[15:12] = bus.digit;
                        2'd1: w_shadow_d[11:8]  = bus.digit;
                        2'd2: w_shadow_d[7:4]   = bus.digit;
                        2'd3: w_shadow_d[3:0]   = bus.digit;
                    endcase
                    w_reg_load_d = 4'b0001 << r_idx;
                    w_reg_data_d = bus.digit;
                    w_idx_d      = r_idx + 2'd1;
                    if (r_idx == 2'd3) w_state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_shadow == PASSWORD) begin
                    w_state_d  = ST_GRANTED;
                    w_access_d = 1'b1;
                    w_tries_d  = TRIES_INIT;
                end else begin
                    w_tries_d   = w_tries_dec;
                    w_bad_d     = 1'b1;
                    w_reg_clr_d = 1'b1;
                    if (w_tries_dec == '0) begin
                        w_state_d  = ST_LOCKED;
                        w_locked_d = 1'b1;
`ifdef PEC_LOCK_TIMER_EN
                        w_lock_cnt_d = LOCK_INIT;
`endif
                    end else begin
                        w_state_d = ST_FAIL;
                    end
                end
            end
            ST_FAIL: begin
                w_shadow_d = '0;
                w_idx_d    = '0;
                w_state_d  = ST_ENTRY;
            end
            ST_GRANTED: begin
                w_access_d = 1'b1;
            end
            ST_LOCKED: begin
`ifdef PEC_LOCK_TIMER_EN
                // Leave when the count expires so locked is high for exactly LOCK_CYCLES.
                w_lock_cnt_d = r_lock_cnt - CNT_W'(1);
                if (r_lock_cnt <= CNT_W'(1)) begin
                    w_lock_cnt_d = '0;
                    w_state_d    = ST_ENTRY;
                    w_reg_clr_d  = 1'b1;
                    w_tries_d    = TRIES_INIT;
                    w_shadow_d   = '0;
                    w_idx_d      = '0;
                end else begin
                    w_locked_d = 1'b1;
                end
`else
                w_locked_d = 1'b1;
`endif
            end
            default: w_state_d = ST_ENTRY;
        endcase
    end

    assign bus.reg_load   = r_reg_load;
    assign bus.reg_data   = r_reg_data;
    assign bus.reg_clr    = r_reg_clr;
    assign bus.digit_idx  = r_idx;
    assign bus.access     = r_access;
    assign bus.bad        = r_bad;
    assign bus.locked     = r_locked;
    assign bus.tries_left = r_tries;
endmodule

// File: tb/tb_pass_entry_ctrl.sv
// Directed vector bench for pass_entry_ctrl; checks both lockout builds (PEC_LOCK_TIMER_EN).
module tb_pass_entry_ctrl;
    localparam int unsigned LOCK_CYC = 8;

    typedef struct packed {
        logic [3:0] load;
        logic [3:0] data;
        logic       clr;
        logic [1:0] idx;
        logic       acc;
        logic       bad;
        logic       lock;
        logic [3:0] tries;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [3:0] dig;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rts = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    pass_entry_ctrl_if bus ();

    pass_entry_ctrl #(
        .PASSWORD    (16'h1234),
        .MAX_TRIES   (3),
        .LOCK_CYCLES (LOCK_CYC)
    ) dut (
        .clk (clk),
        .rts (rts),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o.load  = bus.reg_load;
        o.data  = bus.reg_data;
        o.clr   = bus.reg_clr;
        o.idx   = bus.digit_idx;
        o.acc   = bus.access;
        o.bad   = bus.bad;
        o.lock  = bus.locked;
        o.tries = bus.tries_left;
        return o;
    endfunction

    function automatic void add(input logic r, input logic e, input logic [3:0] d,
                                input logic [3:0] ld, input logic [3:0] dt, input logic c,
                                input logic [1:0] ix, input logic a, input logic b,
                                input logic lk, input logic [3:0] t);
        vec_t v;
        v.rst = r; v.en = e; v.dig = d;
        v.exp.load = ld; v.exp.data = dt; v.exp.clr = c; v.exp.idx = ix;
        v.exp.acc = a; v.exp.bad = b; v.exp.lock = lk; v.exp.tries = t;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            rts       = vecs[i].rst;
            bus.enter = vecs[i].en;
            bus.digit = vecs[i].dig;
            step();
            check($sformatf("vec%0d", i), 32'(sample()), 32'(vecs[i].exp));
        end
        rts       = 1'b0;
        bus.enter = 1'b0;
    endtask

    initial begin
        int split;
        int lock_cnt;
        bus.enter = 1'b0;
        bus.digit = 4'd0;

        // Correct code, with enter ignored in CHECK and GRANTED
        add(1,0,0, 0,0,1,0,0,0,0,3);
        add(0,1,1, 1,1,0,1,0,0,0,3);
        add(0,1,2, 2,2,0,2,0,0,0,3);
        add(0,1,3, 4,3,0,3,0,0,0,3);
        add(0,1,4, 8,4,0,0,0,0,0,3);
        add(0,1,9, 0,4,0,0,1,0,0,3);
        add(0,1,5, 0,4,0,0,1,0,0,3);
        add(0,0,0, 0,4,0,0,1,0,0,3);
        // Single failure, then next digit lands in slot 0
        add(1,0,0, 0,0,1,0,0,0,0,3);
        add(0,1,1, 1,1,0,1,0,0,0,3);
        add(0,1,2, 2,2,0,2,0,0,0,3);
        add(0,1,3, 4,3,0,3,0,0,0,3);
        add(0,1,5, 8,5,0,0,0,0,0,3);
        add(0,1,7, 0,5,1,0,0,1,0,2);
        add(0,1,7, 0,5,0,0,0,0,0,2);
        add(0,1,6, 1,6,0,1,0,0,0,2);
        add(0,1,0, 2,0,0,2,0,0,0,2);
        add(0,1,0, 4,0,0,3,0,0,0,2);
        add(0,1,0, 8,0,0,0,0,0,0,2);
        add(0,0,0, 0,0,1,0,0,1,0,1);
        add(0,0,0, 0,0,0,0,0,0,0,1);
        // Third failure locks out
        add(0,1,9, 1,9,0,1,0,0,0,1);
        add(0,1,9, 2,9,0,2,0,0,0,1);
        add(0,1,9, 4,9,0,3,0,0,0,1);
        add(0,1,9, 8,9,0,0,0,0,0,1);
        add(0,0,0, 0,9,1,0,0,1,1,0);
        add(0,1,1, 0,9,0,0,0,0,1,0);
        split = vecs.size();
        // Reset overrides enter, reset mid-entry, then a correct code
        add(1,1,5, 0,0,1,0,0,0,0,3);
        add(0,1,1, 1,1,0,1,0,0,0,3);
        add(0,1,2, 2,2,0,2,0,0,0,3);
        add(1,0,0, 0,0,1,0,0,0,0,3);
        add(0,1,1, 1,1,0,1,0,0,0,3);
        add(0,1,2, 2,2,0,2,0,0,0,3);
        add(0,1,3, 4,3,0,3,0,0,0,3);
        add(0,1,4, 8,4,0,0,0,0,0,3);
        add(0,0,0, 0,4,0,0,1,0,0,3);

        run_vecs(0, split);

        // Lockout duration; two locked cycles already observed in the table
        lock_cnt = 2;
`ifdef PEC_LOCK_TIMER_EN
        for (int i = 0; i < 200; i++) begin
            bus.enter = 1'b1;
            bus.digit = 4'(i);
            step();
            if (!bus.locked) break;
            lock_cnt++;
            check("no_load_locked", 32'(bus.reg_load), 32'd0);
        end
        bus.enter = 1'b0;
        check("lock_len", 32'(lock_cnt), 32'(LOCK_CYC));
        check("unlock_state", 32'({bus.locked, bus.reg_clr, bus.bad, bus.tries_left}),
              32'({1'b0, 1'b1, 1'b0, 4'd3}));
        step();
        check("unlock_clr_drop", 32'({bus.reg_clr, bus.locked, bus.reg_load}), 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            bus.enter = 1'b1;
            bus.digit = 4'(i);
            step();
            if (bus.locked) lock_cnt++;
            check("no_load_locked", 32'(bus.reg_load), 32'd0);
        end
        bus.enter = 1'b0;
        check("lock_held", 32'(lock_cnt), 32'd102);
        rts = 1'b1;
        step();
        rts = 1'b0;
        check("lock_rts_clear", 32'({bus.locked, bus.reg_clr, bus.tries_left}),
              32'({1'b0, 1'b1, 4'd3}));
`endif

        run_vecs(split, vecs.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
